// File: rtl/ula_32_bits_serial_if.sv
// Request/result handshake bundle for the byte-serial 32-bit 74181-style ALU.
interface ula_32_bits_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  s;
  logic        m;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic        c_out;
  logic        a_eq_b;
  logic        overflow;
  logic        p;
  logic        g;

  modport master (
    output in_valid, a, b, s, m, c_in, out_ready,
    input  in_ready, out_valid, f, c_out, a_eq_b, overflow, p, g
  );

  modport slave (
    input  in_valid, a, b, s, m, c_in, out_ready,
    output in_ready, out_valid, f, c_out, a_eq_b, overflow, p, g
  );
endinterface

// File: rtl/ula_32_bits_serial.sv
// 32-bit 74181-style ALU evaluated one byte per cycle through a single 8-bit slice,
// with carries chained across bytes and a valid/ready handshake on both sides.
module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b,
  output logic       overflow,
  output logic       p,
  output logic       g
);
  logic [7:0] prop;
  logic [7:0] gen;
  logic [7:0] half;
  logic [7:0] sum;
  logic       c_run;
  logic       g_run;
  logic       c_into_msb;

  // The slice adds prop + gen + c_in; gen is always a subset of prop, so each
  // bit propagates on prop and generates on gen, and logic mode is ~(prop ^ gen).
  always_comb begin
    prop       = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    gen        = (a & b & {8{s[3]}}) | (a & ~b & {8{s[2]}});
    half       = prop & ~gen;
    sum        = '0;
    c_run      = c_in;
    g_run      = 1'b0;
    c_into_msb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = half[i] ^ c_run;
      if (i == 7) c_into_msb = c_run;
      c_run = gen[i] | (prop[i] & c_run);
      g_run = gen[i] | (prop[i] & g_run);
    end
    f        = m ? ~half : sum;
    c_out    = c_run;
    a_eq_b   = &f;
    p        = &prop;
    g        = g_run;
    overflow = ~m & ((s == 4'b1001) | (s == 4'b0110)) & (c_into_msb ^ c_run);
  end
endmodule

module ula_32_bits_serial (
  input  logic                 clk,
  input  logic                 rst,
  ula_32_bits_serial_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  idx_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  s_q;
  logic        m_q;
  logic        c_in_q;
  logic        carry_q;
  logic [31:0] f_q;
  logic        c_out_q;
  logic        a_eq_b_q;
  logic        overflow_q;
  logic        p_q;
  logic        g_q;

  logic [4:0]  byte_lsb;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_f;
  logic        alu_c_in;
  logic        alu_c_out;
  logic        alu_a_eq_b;
  logic        alu_overflow;
  logic        alu_p;
  logic        alu_g;

  assign byte_lsb = {idx_q[1:0], 3'b000};
  assign alu_a    = a_q[byte_lsb +: 8];
  assign alu_b    = b_q[byte_lsb +: 8];
  assign alu_c_in = (idx_q == 3'd0) ? c_in_q : carry_q;

  ula_8_bits u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .s        (s_q),
    .m        (m_q),
    .c_in     (alu_c_in),
    .f        (alu_f),
    .c_out    (alu_c_out),
    .a_eq_b   (alu_a_eq_b),
    .overflow (alu_overflow),
    .p        (alu_p),
    .g        (alu_g)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // RUN spends idx 0..3 on the bytes and one extra edge at idx 4 before presenting the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)      state_d = RUN;
      RUN:     if (idx_q == 3'd4)     state_d = DONE;
      DONE:    if (bus.out_ready)     state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      c_in_q     <= 1'b0;
      carry_q    <= 1'b0;
      f_q        <= '0;
      c_out_q    <= 1'b0;
      a_eq_b_q   <= 1'b0;
      overflow_q <= 1'b0;
      p_q        <= 1'b0;
      g_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            s_q    <= bus.s;
            m_q    <= bus.m;
            c_in_q <= bus.c_in;
            idx_q  <= '0;
          end
        end
        RUN: begin
          if (idx_q != 3'd4) begin
            f_q[byte_lsb +: 8] <= alu_f;
            carry_q            <= alu_c_out;
            idx_q              <= idx_q + 3'd1;
            if (idx_q == 3'd0) begin
              a_eq_b_q <= alu_a_eq_b;
              p_q      <= alu_p;
              g_q      <= alu_g;
            end else begin
              a_eq_b_q <= a_eq_b_q & alu_a_eq_b;
              p_q      <= p_q & alu_p;
              g_q      <= alu_g | (alu_p & g_q);
            end
            if (idx_q == 3'd3) begin
              c_out_q    <= alu_c_out;
              overflow_q <= alu_overflow;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.f         = f_q;
  assign bus.c_out     = c_out_q;
  assign bus.a_eq_b    = a_eq_b_q;
  assign bus.overflow  = overflow_q;
  assign bus.p         = p_q;
  assign bus.g         = g_q;
endmodule

// File: tb/tb_ula_32_bits_serial.sv
// Self-checking bench for ula_32_bits_serial: directed corner cases plus a randomized
// sweep against a 32-bit function-table model of the 74181.
module tb_ula_32_bits_serial;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ula_32_bits_serial_if bus ();

  ula_32_bits_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all result outputs: {f, c_out, a_eq_b, overflow, p, g}.
  logic [36:0] dut_out;
  assign dut_out = {bus.f, bus.c_out, bus.a_eq_b, bus.overflow, bus.p, bus.g};

  // Datasheet view: arithmetic is x plus y plus carry, logic mode is a plain boolean table.
  function automatic logic [36:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s, input logic m, input logic cin);
    logic [31:0] x, y, lf, f;
    logic [32:0] sum, gsum;
    logic        ovf;
    x = a; y = '0; lf = '0;
    case (s)
      4'b0000: begin x = a;            y = '0;           lf = ~a;         end
      4'b0001: begin x = a | b;        y = '0;           lf = ~(a | b);   end
      4'b0010: begin x = a | ~b;       y = '0;           lf = ~a & b;     end
      4'b0011: begin x = 32'hFFFFFFFF; y = '0;           lf = '0;         end
      4'b0100: begin x = a;            y = a & ~b;       lf = ~(a & b);   end
      4'b0101: begin x = a | b;        y = a & ~b;       lf = ~b;         end
      4'b0110: begin x = a;            y = ~b;           lf = a ^ b;      end
      4'b0111: begin x = a & ~b;       y = 32'hFFFFFFFF; lf = a & ~b;     end
      4'b1000: begin x = a;            y = a & b;        lf = ~a | b;     end
      4'b1001: begin x = a;            y = b;            lf = ~(a ^ b);   end
      4'b1010: begin x = a | ~b;       y = a & b;        lf = b;          end
      4'b1011: begin x = a & b;        y = 32'hFFFFFFFF; lf = a & b;      end
      4'b1100: begin x = a;            y = a;            lf = 32'hFFFFFFFF; end
      4'b1101: begin x = a | b;        y = a;            lf = a | ~b;     end
      4'b1110: begin x = a | ~b;       y = a;            lf = a | b;      end
      default: begin x = a;            y = 32'hFFFFFFFF; lf = a;          end
    endcase
    sum  = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    gsum = {1'b0, x} + {1'b0, y};
    f    = m ? lf : sum[31:0];
    ovf  = 1'b0;
    if (!m && s == 4'b1001) ovf = (a[31] == b[31]) && (f[31] != a[31]);
    if (!m && s == 4'b0110) ovf = (a[31] != b[31]) && (f[31] != a[31]);
    return {f, sum[32], &f, ovf, &(x | y), gsum[32]};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request, scrambles the inputs after acceptance and waits for the result.
  task automatic apply_stimulus(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                                input logic [3:0] ts, input logic tm, input logic tc,
                                output logic [36:0] got);
    logic [36:0] exp;
    int waited;
    int edges;
    exp = ref_model(ta, tb, ts, tm, tc);
    @(negedge clk);
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output({tag, " ready"}, 64'(bus.in_ready), 64'd1);
    bus.a = ta; bus.b = tb; bus.s = ts; bus.m = tm; bus.c_in = tc;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    bus.s = 4'($urandom); bus.m = 1'($urandom); bus.c_in = 1'($urandom);
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    got = dut_out;
    check_output({tag, " latency"}, 64'(edges), 64'd5);
    check_output({tag, " result"}, 64'(got), 64'(exp));
  endtask

  task automatic take_result;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [36:0] got;
    logic        stable;
    logic        seen_valid;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.c_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset outputs", 64'(dut_out), 64'd0);
    check_output("reset out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("post-reset in_ready", 64'(bus.in_ready), 64'd1);

    apply_stimulus("ripple", 32'h0000FFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0, got);
    check_output("ripple f", 64'(got[36:5]), 64'h00010000);
    check_output("ripple c_out", 64'(got[4]), 64'd0);
    check_output("ripple overflow", 64'(got[2]), 64'd0);
    take_result();

    apply_stimulus("signed ovf", 32'h7FFFFFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0, got);
    check_output("signed ovf f", 64'(got[36:5]), 64'h80000000);
    check_output("signed ovf overflow", 64'(got[2]), 64'd1);
    check_output("signed ovf c_out", 64'(got[4]), 64'd0);
    take_result();

    apply_stimulus("wrap", 32'hFFFFFFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0, got);
    check_output("wrap f", 64'(got[36:5]), 64'h00000000);
    check_output("wrap c_out", 64'(got[4]), 64'd1);
    check_output("wrap overflow", 64'(got[2]), 64'd0);
    take_result();

    for (int c = 0; c < 2; c++) begin
      apply_stimulus("logic xor", 32'hAAAAAAAA, 32'h55555555, 4'b0110, 1'b1, 1'(c), got);
      check_output("logic xor f", 64'(got[36:5]), 64'hFFFFFFFF);
      check_output("logic xor a_eq_b", 64'(got[3]), 64'd1);
      check_output("logic xor overflow", 64'(got[2]), 64'd0);
      take_result();
    end

    // Result must hold under backpressure and release on a single out_ready pulse.
    apply_stimulus("backpressure", 32'h89ABCDEF, 32'h12345678, 4'b0110, 1'b0, 1'b1, got);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dut_out !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    check_output("backpressure hold", 64'(stable), 64'd1);
    take_result();
    check_output("handshake out_valid", 64'(bus.out_valid), 64'd0);
    check_output("handshake in_ready", 64'(bus.in_ready), 64'd1);

    repeat (3) @(negedge clk);
    check_output("idle hold outputs", 64'(dut_out), 64'(got));
    check_output("idle out_valid", 64'(bus.out_valid), 64'd0);

    // Reset while byte 2 is about to be processed.
    @(negedge clk);
    bus.a = 32'h12345678; bus.b = 32'h11111111; bus.s = 4'b1001; bus.m = 1'b0; bus.c_in = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("mid-run low bytes", 64'(bus.f[15:0]), 64'h6789);
    rst = 1'b1;
    #1;
    check_output("mid-run reset outputs", 64'(dut_out), 64'd0);
    check_output("mid-run reset out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check_output("discarded request", 64'(seen_valid), 64'd0);
    apply_stimulus("after reset", 32'h00000001, 32'h00000001, 4'b1001, 1'b0, 1'b0, got);
    check_output("after reset f", 64'(got[36:5]), 64'h00000002);
    take_result();

    for (int ms = 0; ms < 32; ms++) begin
      for (int n = 0; n < 200; n++) begin
        apply_stimulus("random", $urandom, $urandom, 4'(ms), 1'(ms >> 4), 1'($urandom_range(0, 1)), got);
        take_result();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
